jt51_pgx: RTL

Parametrised, time-multiplexed phase generator back end for the next-generation JT51 operator pipeline. It takes a per-slot base phase increment, detune offset and multiplier, and produces a per-slot accumulated phase. It keeps one phase accumulator per slot in an internal register array of configurable depth. Compared with the current generator it adds:

- configurable slot count and accumulator/output widths;
- detune underflow saturation;
- a per-slot phase hold (freeze);
- a wrap strobe for oscillator hard-sync.

---
 rtl/jt51_pgx_pkg.sv | 26 ++
 rtl/jt51_pgx_acc.sv | 46 ++++
 rtl/jt51_pgx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jt51_pgx_pkg.sv
// jt51_pgx_pkg: shared constants and helper functions for the jt51_pgx
// phase generator back end.
package jt51_pgx_pkg;

  // Default clamp applied to the per-slot base phase increment.
  localparam int PGX_LIMIT_DEF = 32'd82976;

  // Width of a slot index for a given slot count (never below 1 bit).
  function automatic int pgx_slot_w(input int slots);
    return (slots > 32'd1) ? $clog2(slots) : 32'd1;
  endfunction

  // Frequency multiplier. A multiplier of 0 means x1/2. The result is
  // deliberately wide; callers truncate it to the accumulator width, which
  // gives the modulo behaviour.
  function automatic logic [35:0] pgx_mul(input logic [31:0] d, input logic [3:0] mul);
    logic [35:0] r;
    if (mul == 4'd0) begin
      r = {5'd0, d[31:1]};
    end else begin
      r = {4'd0, d} * {32'd0, mul};
    end
    return r;
  endfunction

endpackage

// File: rtl/jt51_pgx_acc.sv
// jt51_pgx_acc: SLOTS x PHW phase accumulator array. The read address is
// registered, so read data for a slot appears one enabled cycle after its
// address is presented. Reset clears every entry.
module jt51_pgx_acc
  import jt51_pgx_pkg::*;
#(
  parameter int SLOTS = 32,
  parameter int PHW   = 20,
  parameter int AW    = pgx_slot_w(SLOTS)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           cen,
  input  logic [AW-1:0]  raddr,
  output logic [PHW-1:0] rdata,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [PHW-1:0] wdata
);

  logic [PHW-1:0] mem [SLOTS];
  logic [AW-1:0]  raddr_q;

  // Latch the read address on each enabled cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      raddr_q <= {AW{1'b0}};
    end else if (cen) begin
      raddr_q <= raddr;
    end
  end

  assign rdata = mem[raddr_q];

  // Clear the whole array on reset, otherwise write back the new phase.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < SLOTS; i++) begin
        mem[i] <= {PHW{1'b0}};
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/jt51_pgx.sv
// jt51_pgx: time-multiplexed phase generator back end. Four-stage pipeline
// (clamp, detune, multiply, accumulate) followed by an output register, so
// an input sampled on enabled edge n appears on the outputs at edge n+4.
module jt51_pgx
  import jt51_pgx_pkg::*;
#(
  parameter int SLOTS = 32,
  parameter int BASEW = 18,
  parameter int PHW   = 20,
  parameter int OUTW  = 10,
  parameter int DTW   = 5,
  parameter int LIMIT = PGX_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     zero,
  input  logic [BASEW-1:0]         base_I,
  input  logic [DTW-1:0]           dt_off_I,
  input  logic                     dt_neg_I,
  input  logic [3:0]               mul_I,
  input  logic                     pg_rst_I,
  input  logic                     hold_I,
  output logic [$clog2(SLOTS)-1:0] slot_O,
  output logic [OUTW-1:0]          phase_O,
  output logic [PHW-1:0]           step_O,
  output logic                     wrap_O
);

  localparam int SW = pgx_slot_w(SLOTS);
  localparam logic [BASEW-1:0] LIM = BASEW'(LIMIT);

  // Slot numbering
  logic [SW-1:0] scnt;
  logic [SW-1:0] in_slot;

  // Stage I: clamped base
  logic             s1_valid;
  logic [SW-1:0]    s1_slot;
  logic [BASEW-1:0] s1_base;
  logic [DTW-1:0]   s1_dt;
  logic             s1_neg;
  logic [3:0]       s1_mul;
  logic             s1_rst;
  logic             s1_hold;
  logic [BASEW-1:0] b1;

  // Stage II: detuned increment
  logic             s2_valid;
  logic [SW-1:0]    s2_slot;
  logic [BASEW:0]   s2_d;
  logic [3:0]       s2_mul;
  logic             s2_rst;
  logic             s2_hold;
  logic [BASEW:0]   b1_ext;
  logic [BASEW:0]   dt_ext;
  logic [BASEW:0]   d2;

  // Stage III: multiplied step
  logic             s3_valid;
  logic [SW-1:0]    s3_slot;
  logic [PHW-1:0]   s3_step;
  logic             s3_rst;
  logic             s3_hold;
  logic [PHW-1:0]   s3_calc;

  // Stage IV: accumulated phase
  logic             s4_valid;
  logic [SW-1:0]    s4_slot;
  logic [PHW-1:0]   s4_acc;
  logic [PHW-1:0]   s4_step;
  logic             s4_wrap;
  logic [PHW-1:0]   rd_data;
  logic [PHW:0]     sum;
  logic [PHW-1:0]   new_acc;
  logic             new_wrap;
  logic             acc_we;

  // A zero marker forces the current input to slot 0; numbering continues from there.
  assign in_slot = zero ? {SW{1'b0}} : scnt;

  // Slot counter advances once per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= {SW{1'b0}};
    end else if (cen) begin
      scnt <= in_slot + {{(SW-1){1'b0}}, 1'b1};
    end
  end

  assign b1 = (base_I > LIM) ? LIM : base_I;

  // Stage I register: clamped base plus control travelling with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_slot  <= {SW{1'b0}};
      s1_base  <= {BASEW{1'b0}};
      s1_dt    <= {DTW{1'b0}};
      s1_neg   <= 1'b0;
      s1_mul   <= 4'd0;
      s1_rst   <= 1'b0;
      s1_hold  <= 1'b0;
    end else if (cen) begin
      s1_valid <= 1'b1;
      s1_slot  <= in_slot;
      s1_base  <= b1;
      s1_dt    <= dt_off_I;
      s1_neg   <= dt_neg_I;
      s1_mul   <= mul_I;
      s1_rst   <= pg_rst_I;
      s1_hold  <= hold_I;
    end
  end

  assign b1_ext = {1'b0, s1_base};
  assign dt_ext = (BASEW+1)'(s1_dt);

  // Detune: negative offsets saturate at zero instead of wrapping.
  always_comb begin
    d2 = b1_ext + dt_ext;
    if (!s1_neg) begin
      d2 = b1_ext + dt_ext;
    end else if (b1_ext < dt_ext) begin
      d2 = {(BASEW+1){1'b0}};
    end else begin
      d2 = b1_ext - dt_ext;
    end
  end

  // Stage II register: detuned increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_slot  <= {SW{1'b0}};
      s2_d     <= {(BASEW+1){1'b0}};
      s2_mul   <= 4'd0;
      s2_rst   <= 1'b0;
      s2_hold  <= 1'b0;
    end else if (cen) begin
      s2_valid <= s1_valid;
      s2_slot  <= s1_slot;
      s2_d     <= d2;
      s2_mul   <= s1_mul;
      s2_rst   <= s1_rst;
      s2_hold  <= s1_hold;
    end
  end

  assign s3_calc = PHW'(pgx_mul(32'(s2_d), s2_mul));

  // Stage III register: step to add; the accumulator read is issued alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_slot  <= {SW{1'b0}};
      s3_step  <= {PHW{1'b0}};
      s3_rst   <= 1'b0;
      s3_hold  <= 1'b0;
    end else if (cen) begin
      s3_valid <= s2_valid;
      s3_slot  <= s2_slot;
      s3_step  <= s3_calc;
      s3_rst   <= s2_rst;
      s3_hold  <= s2_hold;
    end
  end

  assign sum = {1'b0, rd_data} + {1'b0, s3_step};

  // Accumulate with priority: phase reset, then hold, then add.
  always_comb begin
    new_acc  = sum[PHW-1:0];
    new_wrap = 1'b0;
    if (s3_rst) begin
      new_acc  = {PHW{1'b0}};
      new_wrap = 1'b0;
    end else if (s3_hold) begin
      new_acc  = rd_data;
      new_wrap = 1'b0;
    end else begin
      new_acc  = sum[PHW-1:0];
      new_wrap = sum[PHW];
    end
  end

  // Invalid (post-reset) pipeline entries never touch the array.
  assign acc_we = cen & s3_valid;

  jt51_pgx_acc #(
    .SLOTS (SLOTS),
    .PHW   (PHW),
    .AW    (SW)
  ) u_acc (
    .clk   (clk),
    .clr   (rst),
    .cen   (cen),
    .raddr (s2_slot),
    .rdata (rd_data),
    .we    (acc_we),
    .waddr (s3_slot),
    .wdata (new_acc)
  );

  // Stage IV register: new phase, applied step and carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      s4_valid <= 1'b0;
      s4_slot  <= {SW{1'b0}};
      s4_acc   <= {PHW{1'b0}};
      s4_step  <= {PHW{1'b0}};
      s4_wrap  <= 1'b0;
    end else if (cen) begin
      s4_valid <= s3_valid;
      s4_slot  <= s3_slot;
      s4_acc   <= new_acc;
      s4_step  <= s3_step;
      s4_wrap  <= new_wrap;
    end
  end

  // Output register: zeros until valid data reaches the end of the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_O  <= {SW{1'b0}};
      phase_O <= {OUTW{1'b0}};
      step_O  <= {PHW{1'b0}};
      wrap_O  <= 1'b0;
    end else if (cen) begin
      if (s4_valid) begin
        slot_O  <= s4_slot;
        phase_O <= s4_acc[PHW-1 -: OUTW];
        step_O  <= s4_step;
        wrap_O  <= s4_wrap;
      end else begin
        slot_O  <= {SW{1'b0}};
        phase_O <= {OUTW{1'b0}};
        step_O  <= {PHW{1'b0}};
        wrap_O  <= 1'b0;
      end
    end
  end

endmodule
